apb4_mst_bridge: RTL and testbench

APB4_MST_BRIDGE -- requirements
Module: apb4_mst_bridge

---
 rtl/apb4_mst_bridge_if.sv | 28 ++
 rtl/apb4_mst_bridge.sv | 139 +++++++++++++
 tb/tb_apb4_mst_bridge.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb4_mst_bridge_if.sv
// rtl/apb4_mst_bridge_if.sv - APB4 bus bundle shared by the bridge and its completer
//
// Signals:
//   paddr, pprot, psel, penable, pwrite, pwdata, pstrb : requester -> completer
//   pready, prdata, pslverr                            : completer -> requester
// Modports: master (requester side), slave (completer side).
interface apb4_if;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb4_mst_bridge.sv
// rtl/apb4_mst_bridge.sv - single-outstanding request/response to APB4 requester bridge
//
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_valid_i/ready_o   : request handshake; ready only while idle
//   req_addr_i, req_write_i, req_wdata_i, req_wstrb_i, req_prot_i : request fields
//   rsp_valid_o/ready_i   : response handshake
//   rsp_rdata_o, rsp_err_o: read data (0 for writes), pslverr or timeout
//   apb                   : APB4 requester port (apb4_if.master)
// Optional feature: define APB4_MST_TIMEOUT_EN to build a 16-bit ACCESS timeout
// counter that aborts a transfer after TIMEOUT_CYCLES cycles without pready.
module apb4_mst_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_write_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  input  logic [2:0]  req_prot_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  apb4_if.master      apb
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb4_mst_bridge: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [3:0]  strb_q;
  logic [2:0]  prot_q;
  logic        timeout;

`ifdef APB4_MST_TIMEOUT_EN
  // Counter rests at zero outside ACCESS, so it is already clear on entry.
  // The abort fires in the ACCESS cycle whose count reaches TIMEOUT_CYCLES,
  // giving exactly TIMEOUT_CYCLES cycles of psel/penable.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != ACCESS) begin
      to_cnt_q <= 16'd0;
    end else if (!apb.pready) begin
      to_cnt_q <= to_cnt_q + 16'd1;
    end
  end

  // pready in the same cycle takes priority over the abort.
  assign timeout = (state_q == ACCESS) && !apb.pready && (to_cnt_q == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = !rst_i;
        if (req_valid_i && !rst_i) state_d = SETUP;
      end
      SETUP: begin
        apb.psel = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        apb.psel    = 1'b1;
        apb.penable = 1'b1;
        if (apb.pready || timeout) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields are latched once and held on the bus until the next
  // acceptance, so paddr/pwdata keep their last values while idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      write_q     <= 1'b0;
      strb_q      <= 4'd0;
      prot_q      <= 3'd0;
      rsp_rdata_o <= 32'd0;
      rsp_err_o   <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid_i) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        write_q <= req_write_i;
        strb_q  <= req_write_i ? req_wstrb_i : 4'd0;
        prot_q  <= req_prot_i;
      end
      if (state_q == ACCESS) begin
        if (apb.pready) begin
          rsp_rdata_o <= write_q ? 32'd0 : apb.prdata;
          rsp_err_o   <= apb.pslverr;
        end else if (timeout) begin
          rsp_rdata_o <= 32'd0;
          rsp_err_o   <= 1'b1;
        end
      end
    end
  end

  assign apb.paddr  = addr_q;
  assign apb.pwdata = wdata_q;
  assign apb.pwrite = write_q;
  assign apb.pstrb  = strb_q;
  assign apb.pprot  = prot_q;

endmodule

// File: tb/tb_apb4_mst_bridge.sv
// tb/tb_apb4_mst_bridge.sv - scoreboard bench for apb4_mst_bridge
module tb_apb4_mst_bridge;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_write_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic [2:0]  req_prot_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  apb4_if apb ();

  apb4_mst_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_write_i (req_write_i),
    .req_wdata_i (req_wdata_i),
    .req_wstrb_i (req_wstrb_i),
    .req_prot_i  (req_prot_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .apb         (apb)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int          slv_wait  = 0;
  bit          slv_never = 0;
  logic [31:0] slv_rdata = 32'd0;
  logic        slv_err   = 1'b0;
  int          acc_n     = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Completer model: inside ACCESS it answers after slv_wait wait states;
  // outside ACCESS it drives deliberately bogus values that must be ignored.
  always @(negedge clk) begin
    if (apb.psel && apb.penable) begin
      apb.pready  = !slv_never && (acc_n >= slv_wait);
      apb.prdata  = slv_rdata;
      apb.pslverr = slv_err;
      acc_n++;
    end else begin
      apb.pready  = 1'b1;
      apb.prdata  = 32'hBAD0_BAD0;
      apb.pslverr = 1'b1;
      acc_n       = 0;
    end
  end

  // Response monitor: every completed response handshake pops one expectation.
  always @(negedge clk) begin
    if (rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd0, 32'd1);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata_o, e.rdata);
        chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [2:0] prot);
    int n;
    @(negedge clk);
    req_addr_i  = addr;
    req_write_i = wr;
    req_wdata_i = wdata;
    req_wstrb_i = wstrb;
    req_prot_i  = prot;
    req_valid_i = 1'b1;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_at_issue", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  // Counts cycles from acceptance to rsp_valid and checks bus stability.
  task automatic await_rsp(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic [2:0] prot,
                           output int lat, output int acc);
    lat = 0;
    acc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (apb.psel && apb.penable) begin
        acc++;
        chk("access_paddr", apb.paddr, addr);
        chk("access_pwdata", apb.pwdata, wdata);
        chk("access_pstrb", 32'(apb.pstrb), wr ? 32'(wstrb) : 32'd0);
        chk("access_pwrite", 32'(apb.pwrite), 32'(wr));
        chk("access_pprot", 32'(apb.pprot), 32'(prot));
      end else if (lat == 1) begin
        chk("setup_psel_penable", 32'({apb.psel, apb.penable}), 32'b10);
      end
    end while (!rsp_valid_o && lat < 40);
  endtask

  initial begin
    int lat, acc, cnt;
    rsp_t r;
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = 32'd0;
    req_write_i = 1'b0;
    req_wdata_i = 32'd0;
    req_wstrb_i = 4'd0;
    req_prot_i  = 3'd0;
    rsp_ready_i = 1'b1;
    apb.pready  = 1'b0;
    apb.prdata  = 32'd0;
    apb.pslverr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready_o), 32'd0);
    chk("rst_psel_penable", 32'({apb.psel, apb.penable}), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_paddr", apb.paddr, 32'd0);
    chk("rst_pwdata", apb.pwdata, 32'd0);
    chk("rst_pstrb_pwrite_pprot", 32'({apb.pstrb, apb.pwrite, apb.pprot}), 32'd0);
    chk("rst_rsp_data", 32'({rsp_err_o, rsp_rdata_o}), 32'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready_o), 32'd1);

    // Zero-wait read; strobes supplied must not reach pstrb
    slv_wait = 0; slv_rdata = 32'hDEAD_BEEF; slv_err = 1'b0;
    r.rdata = 32'hDEAD_BEEF; r.err = 1'b0; exp_q.push_back(r);
    issue(32'h1000_0004, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b010);
    await_rsp(32'h1000_0004, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b010, lat, acc);
    chk("read0_latency", 32'(lat), 32'd3);
    chk("read0_access_cycles", 32'(acc), 32'd1);

    // Two-wait write; prdata on the bus must not leak into the response
    slv_wait = 2; slv_rdata = 32'hCAFE_F00D; slv_err = 1'b0;
    r.rdata = 32'd0; r.err = 1'b0; exp_q.push_back(r);
    issue(32'h2000_0010, 1'b1, 32'h1234_5678, 4'b0011, 3'b001);
    await_rsp(32'h2000_0010, 1'b1, 32'h1234_5678, 4'b0011, 3'b001, lat, acc);
    chk("write2_latency", 32'(lat), 32'd5);
    chk("write2_access_cycles", 32'(acc), 32'd3);

    // Slave error with response backpressure
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
    slv_wait = 0; slv_rdata = 32'h5555_AAAA; slv_err = 1'b1;
    r.rdata = 32'h5555_AAAA; r.err = 1'b1; exp_q.push_back(r);
    issue(32'h0000_0040, 1'b0, 32'h0, 4'h0, 3'b000);
    await_rsp(32'h0000_0040, 1'b0, 32'h0, 4'h0, 3'b000, lat, acc);
    chk("err_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_rsp_err", 32'(rsp_err_o), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata_o, 32'h5555_AAAA);
      chk("bp_req_ready", 32'(req_ready_o), 32'd0);
      chk("bp_psel", 32'(apb.psel), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_released_valid", 32'(rsp_valid_o), 32'd0);
    chk("bp_released_req_ready", 32'(req_ready_o), 32'd1);
    slv_err = 1'b0;

    // Completer never answers
    slv_never = 1'b1;
    issue(32'h4000_0000, 1'b0, 32'h0, 4'h0, 3'b000);
    @(negedge clk);
    chk("to_setup", 32'({apb.psel, apb.penable}), 32'b10);
`ifdef APB4_MST_TIMEOUT_EN
    r.rdata = 32'd0; r.err = 1'b1; exp_q.push_back(r);
    cnt = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (apb.psel && apb.penable) cnt++;
    end while (apb.psel && lat < 50);
    chk("to_access_cycles", 32'(cnt), 32'd8);
    chk("to_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("to_rsp_err", 32'(rsp_err_o), 32'd1);
    chk("to_rsp_rdata", rsp_rdata_o, 32'd0);
    @(negedge clk);
    slv_never = 1'b0;
`else
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (apb.psel && apb.penable) cnt++;
    end
    chk("noto_access_cycles", 32'(cnt), 32'd1000);
    chk("noto_rsp_valid", 32'(rsp_valid_o), 32'd0);
    @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    slv_never = 1'b0;
    @(negedge clk);
    chk("noto_recovered_ready", 32'(req_ready_o), 32'd1);
`endif

    // Reset during the second ACCESS cycle abandons the transfer
    slv_wait = 6; slv_rdata = 32'h7777_0000;
    issue(32'h5000_0008, 1'b1, 32'h0BAD_F00D, 4'hF, 3'b100);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_access_active", 32'({apb.psel, apb.penable}), 32'b11);
    rst_i = 1'b1;
    @(negedge clk);
    chk("mid_rst_psel", 32'({apb.psel, apb.penable}), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("mid_rel_req_ready", 32'(req_ready_o), 32'd1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid_o || apb.psel) cnt++;
    end
    chk("mid_rel_quiet", 32'(cnt), 32'd0);

    // Recovery: zero-wait write after reset
    slv_wait = 0; slv_rdata = 32'h1111_2222;
    r.rdata = 32'd0; r.err = 1'b0; exp_q.push_back(r);
    issue(32'h3000_0000, 1'b1, 32'hA5A5_0001, 4'b1100, 3'b011);
    await_rsp(32'h3000_0000, 1'b1, 32'hA5A5_0001, 4'b1100, 3'b011, lat, acc);
    chk("recover_latency", 32'(lat), 32'd3);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
